matmul_lanes: RTL and testbench

// - Memory-mapped integer matrix multiplier: C[MxN] = A[MxK] * B[KxN], all matrices in one shared word memory.
// - Computes LANES output columns of C per pass. Each A element is fetched once per pass and reused across LANES B fetches.
// - Sits on the shared single-port memory bus. The bus has a request/grant handshake and in-order read returns.
// - Started by a go pulse from the control sequencer; reports completion on ret.

---
 rtl/matmul_lanes.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_matmul_lanes.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_lanes.sv
// ---------------------------------------------------------------------------
// matmul_lanes
// Memory-mapped integer matrix multiplier: C[MxN] = A[MxK] * B[KxN].
// All three matrices live in one shared single-port word memory reached
// through a request/grant bus with in-order read returns. Each pass
// computes up to LANES output columns of one row of C. Every A element is
// fetched once per pass and reused across the L B elements of that pass.
//
// Optional feature macro: MATMUL_SAT_EN
//   defined   -> accumulation saturates at 2^MEM_DW-1 and sets sticky ovf
//   undefined -> accumulation wraps modulo 2^MEM_DW, ovf stays 0
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   go                    start pulse, sampled only in IDLE
//   aBASE/bBASE/cBASE     base word addresses of A, B, C
//   aSTRIDE/bSTRIDE/cSTRIDE  row pitch in words
//   aROWS/aCOLS/bCOLS     M, K, N
//   mem_req/mem_write/mem_addr/mem_wdata  bus request, held until mem_gnt
//   mem_gnt               request accepted when mem_req & mem_gnt
//   mem_rdata_vld/mem_rdata  in-order read returns (latency >= 1)
//   busy/ret/ovf          job status
// ---------------------------------------------------------------------------
module matmul_lanes #(
  parameter int MEM_AW    = 16,
  parameter int MEM_DW    = 32,
  parameter int DIM_BITS  = 16,
  parameter int PREC      = 16,
  parameter int LANES     = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  input  logic [MEM_AW-1:0]   aBASE,
  input  logic [MEM_AW-1:0]   bBASE,
  input  logic [MEM_AW-1:0]   cBASE,
  input  logic [DIM_BITS-1:0] aSTRIDE,
  input  logic [DIM_BITS-1:0] bSTRIDE,
  input  logic [DIM_BITS-1:0] cSTRIDE,
  input  logic [DIM_BITS-1:0] aROWS,
  input  logic [DIM_BITS-1:0] aCOLS,
  input  logic [DIM_BITS-1:0] bCOLS,
  output logic                mem_req,
  output logic                mem_write,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [MEM_DW-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rdata_vld,
  input  logic [MEM_DW-1:0]   mem_rdata,
  output logic                busy,
  output logic                ret,
  output logic                ovf
);

  localparam int LW = 5;  // holds 0..16: lane index, tile width, return slot
  localparam int OW = 4;  // holds 0..15 outstanding reads

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_B  = 3'd2,
    S_DRAIN = 3'd3,
    S_WR    = 3'd4,
    S_NXT   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [DIM_BITS-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [LW-1:0]       l_q, l_d;
  logic [DIM_BITS-1:0] dim_m_q, dim_m_d, dim_k_q, dim_k_d, dim_n_q, dim_n_d;
  logic [DIM_BITS-1:0] a_str_q, a_str_d, b_str_q, b_str_d, c_str_q, c_str_d;
  logic [MEM_AW-1:0]   b_base_q, b_base_d;
  // Running row base addresses, advanced by a stride instead of multiplying.
  logic [MEM_AW-1:0]   a_row_q, a_row_d, b_row_q, b_row_d, c_row_q, c_row_d;
  logic                busy_q, busy_d, ret_q, ret_d, ovf_q, ovf_d;
  logic [OW-1:0]       outst_q, outst_d;
  logic [LW-1:0]       rs_q, rs_d;
  logic [PREC-1:0]     a_lat_q, a_lat_d;
  logic [MEM_DW-1:0]   acc_q [LANES];
  logic [MEM_DW-1:0]   acc_d [LANES];

  logic                gnt_s, rd_gnt_s, rd_acc_s, start_s, acc_clr_s;
  logic [DIM_BITS-1:0] rem_s, k_inc_s, j_nxt_s, i_inc_s;
  logic [LW-1:0]       tile_l_s;
  logic [2*PREC-1:0]   prod_s;
  logic [MEM_DW-1:0]   prod_ext_s, lane_old_s;
  logic [MEM_DW:0]     add_res_s;
  logic                unused_s;

  assign busy     = busy_q;
  assign ret      = ret_q;
  assign ovf      = ovf_q;
  assign unused_s = ^mem_rdata[MEM_DW-1:PREC];

  // Bit MEM_DW of the result flags a saturating add; the low bits are the sum.
  function automatic logic [MEM_DW:0] acc_add(input logic [MEM_DW-1:0] x,
                                              input logic [MEM_DW-1:0] y);
    logic [MEM_DW:0] s;
    s = {1'b0, x} + {1'b0, y};
`ifdef MATMUL_SAT_EN
    s[MEM_DW-1:0] = s[MEM_DW] ? {MEM_DW{1'b1}} : s[MEM_DW-1:0];
`else
    s[MEM_DW] = 1'b0;
`endif
    return s;
  endfunction

  assign gnt_s    = mem_req & mem_gnt;
  assign rd_gnt_s = gnt_s & ~mem_write;
  // Returns with nothing outstanding (e.g. stale data after reset) are dropped.
  assign rd_acc_s = mem_rdata_vld & (outst_q != {OW{1'b0}});
  assign rem_s    = dim_n_q - j_q;
  assign tile_l_s = (rem_s < DIM_BITS'(LANES)) ? LW'(rem_s) : LW'(LANES);
  assign k_inc_s  = k_q + DIM_BITS'(1);
  assign i_inc_s  = i_q + DIM_BITS'(1);
  assign j_nxt_s  = j_q + DIM_BITS'(tile_l_s);
  assign prod_s   = {{PREC{1'b0}}, a_lat_q} * {{PREC{1'b0}}, mem_rdata[PREC-1:0]};
  assign prod_ext_s = MEM_DW'(prod_s);

  // Bus request: fields derive only from registered state, so they stay
  // stable while a request waits for its grant.
  always_comb begin
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mem_addr  = {MEM_AW{1'b0}};
    mem_wdata = {MEM_DW{1'b0}};
    case (state_q)
      S_RD_A: begin
        mem_req  = (outst_q < OW'(MAX_OUTST));
        mem_addr = a_row_q + MEM_AW'(k_q);
      end
      S_RD_B: begin
        mem_req  = (outst_q < OW'(MAX_OUTST));
        mem_addr = b_row_q + MEM_AW'(j_q) + MEM_AW'(l_q);
      end
      S_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        mem_addr  = c_row_q + MEM_AW'(j_q) + MEM_AW'(l_q);
        for (int l = 0; l < LANES; l++) begin
          mem_wdata = (l_q == LW'(l)) ? acc_q[l] : mem_wdata;
        end
      end
      default: mem_req = 1'b0;
    endcase
  end

  // Sequencer next state: walks i (rows), j (tiles), k (inner) and l (lane).
  always_comb begin
    state_d  = state_q;
    i_d = i_q;  j_d = j_q;  k_d = k_q;  l_d = l_q;
    dim_m_d  = dim_m_q;  dim_k_d = dim_k_q;  dim_n_d = dim_n_q;
    a_str_d  = a_str_q;  b_str_d = b_str_q;  c_str_d = c_str_q;
    b_base_d = b_base_q;
    a_row_d  = a_row_q;  b_row_d = b_row_q;  c_row_d = c_row_q;
    busy_d   = busy_q;
    ret_d    = ret_q;
    start_s  = 1'b0;
    acc_clr_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          start_s   = 1'b1;
          acc_clr_s = 1'b1;
          i_d = '0;  j_d = '0;  k_d = '0;  l_d = '0;
          dim_m_d  = aROWS;  dim_k_d = aCOLS;  dim_n_d = bCOLS;
          a_str_d  = aSTRIDE;  b_str_d = bSTRIDE;  c_str_d = cSTRIDE;
          b_base_d = bBASE;
          a_row_d  = aBASE;  b_row_d = bBASE;  c_row_d = cBASE;
          if ((aROWS == '0) || (aCOLS == '0) || (bCOLS == '0)) begin
            ret_d  = 1'b1;
            busy_d = 1'b0;
          end else begin
            ret_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = S_RD_A;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_A: begin
        if (gnt_s) begin
          l_d     = '0;
          state_d = S_RD_B;
        end else begin
          state_d = S_RD_A;
        end
      end
      S_RD_B: begin
        if (gnt_s && (l_q == tile_l_s - LW'(1))) begin
          l_d     = '0;
          k_d     = k_inc_s;
          b_row_d = b_row_q + MEM_AW'(b_str_q);
          state_d = (k_inc_s < dim_k_q) ? S_RD_A : S_DRAIN;
        end else if (gnt_s) begin
          l_d = l_q + LW'(1);
        end else begin
          state_d = S_RD_B;
        end
      end
      S_DRAIN: begin
        if (outst_q == {OW{1'b0}}) begin
          l_d     = '0;
          state_d = S_WR;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_WR: begin
        if (gnt_s && (l_q == tile_l_s - LW'(1))) begin
          l_d     = '0;
          state_d = S_NXT;
        end else if (gnt_s) begin
          l_d = l_q + LW'(1);
        end else begin
          state_d = S_WR;
        end
      end
      S_NXT: begin
        acc_clr_s = 1'b1;
        k_d       = '0;
        b_row_d   = b_base_q;
        if (j_nxt_s < dim_n_q) begin
          j_d     = j_nxt_s;
          state_d = S_RD_A;
        end else begin
          j_d     = '0;
          i_d     = i_inc_s;
          a_row_d = a_row_q + MEM_AW'(a_str_q);
          c_row_d = c_row_q + MEM_AW'(c_str_q);
          if (i_inc_s == dim_m_q) begin
            ret_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_RD_A;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Return routing: slot 0 latches the A operand, slot l+1 feeds lane l.
  always_comb begin
    acc_d      = acc_q;
    a_lat_d    = a_lat_q;
    rs_d       = rs_q;
    ovf_d      = ovf_q;
    lane_old_s = {MEM_DW{1'b0}};
    outst_d    = outst_q + OW'(rd_gnt_s) - OW'(rd_acc_s);
    for (int l = 0; l < LANES; l++) begin
      lane_old_s = (rs_q == LW'(l + 1)) ? acc_q[l] : lane_old_s;
    end
    add_res_s = acc_add(lane_old_s, prod_ext_s);
    if (acc_clr_s) begin
      for (int l = 0; l < LANES; l++) begin
        acc_d[l] = {MEM_DW{1'b0}};
      end
      rs_d  = '0;
      ovf_d = start_s ? 1'b0 : ovf_q;
    end else if (rd_acc_s && (rs_q == '0)) begin
      a_lat_d = mem_rdata[PREC-1:0];
      rs_d    = LW'(1);
    end else if (rd_acc_s) begin
      for (int l = 0; l < LANES; l++) begin
        acc_d[l] = (rs_q == LW'(l + 1)) ? add_res_s[MEM_DW-1:0] : acc_q[l];
      end
      ovf_d = ovf_q | add_res_s[MEM_DW];
      rs_d  = (rs_q == tile_l_s) ? LW'(0) : rs_q + LW'(1);
    end else begin
      rs_d = rs_q;
    end
  end

  // State, counter and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      i_q <= '0;  j_q <= '0;  k_q <= '0;  l_q <= '0;
      dim_m_q  <= '0;  dim_k_q <= '0;  dim_n_q <= '0;
      a_str_q  <= '0;  b_str_q <= '0;  c_str_q <= '0;
      b_base_q <= '0;
      a_row_q  <= '0;  b_row_q <= '0;  c_row_q <= '0;
      busy_q   <= 1'b0;
      ret_q    <= 1'b0;
      ovf_q    <= 1'b0;
      outst_q  <= '0;
      rs_q     <= '0;
      a_lat_q  <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= '0;
      end
    end else begin
      state_q  <= state_d;
      i_q <= i_d;  j_q <= j_d;  k_q <= k_d;  l_q <= l_d;
      dim_m_q  <= dim_m_d;  dim_k_q <= dim_k_d;  dim_n_q <= dim_n_d;
      a_str_q  <= a_str_d;  b_str_q <= b_str_d;  c_str_q <= c_str_d;
      b_base_q <= b_base_d;
      a_row_q  <= a_row_d;  b_row_q <= b_row_d;  c_row_q <= c_row_d;
      busy_q   <= busy_d;
      ret_q    <= ret_d;
      ovf_q    <= ovf_d;
      outst_q  <= outst_d;
      rs_q     <= rs_d;
      a_lat_q  <= a_lat_d;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= acc_d[l];
      end
    end
  end

endmodule

// File: tb/tb_matmul_lanes.sv
// Scoreboard bench for matmul_lanes: expected C writes are queued per job,
// the bus model pops and compares them as the DUT writes to memory.
module tb_matmul_lanes;

  logic        clk = 1'b0;
  logic        rst_n, go;
  logic [15:0] aBASE, bBASE, cBASE, aSTRIDE, bSTRIDE, cSTRIDE;
  logic [15:0] aROWS, aCOLS, bCOLS;
  logic        mem_req, mem_write, mem_gnt, mem_rdata_vld;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        busy, ret, ovf;

  matmul_lanes #(.MAX_OUTST(2)) dut (
    .clk(clk), .rst_n(rst_n), .go(go),
    .aBASE(aBASE), .bBASE(bBASE), .cBASE(cBASE),
    .aSTRIDE(aSTRIDE), .bSTRIDE(bSTRIDE), .cSTRIDE(cSTRIDE),
    .aROWS(aROWS), .aCOLS(aCOLS), .bCOLS(bCOLS),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rdata_vld(mem_rdata_vld), .mem_rdata(mem_rdata),
    .busy(busy), .ret(ret), .ovf(ovf)
  );

  always #5 clk = ~clk;

  bit [31:0]   mem [0:65535];
  int          n_cmp = 0, n_err = 0;
  int          cyc = 0, rd_cnt = 0, wr_cnt = 0, req_cnt = 0;
  int          stray_n = 0, max_out = 0, stab_err = 0;
  bit          rand_mode = 1'b0;
  logic [31:0] rq_d [$];
  int          rq_t [$];
  logic [15:0] exp_a [$];
  logic [31:0] exp_d [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [31:0] d);
    exp_a.push_back(a);
    exp_d.push_back(d);
  endtask

  // Bus model and write monitor, evaluated mid-cycle (negedge).
  initial begin
    bit          p_pend = 1'b0;
    logic [15:0] p_addr;
    logic [31:0] p_wd;
    logic        p_wr;
    int          t;
    mem_gnt = 1'b0; mem_rdata_vld = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rq_t.size() > 0 && rq_t[0] <= cyc) begin
        mem_rdata_vld = 1'b1;
        mem_rdata     = rq_d.pop_front();
        void'(rq_t.pop_front());
      end else if (rq_t.size() == 0 && stray_n > 0) begin
        mem_rdata_vld = 1'b1;
        mem_rdata     = 32'h0005_0005;
        stray_n--;
      end else begin
        mem_rdata_vld = 1'b0;
        mem_rdata     = 32'h0;
      end
      mem_gnt = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_req) req_cnt++;
      if (p_pend && rst_n &&
          !(mem_req && mem_addr == p_addr && mem_write == p_wr && mem_wdata == p_wd))
        stab_err++;
      if (mem_req && mem_gnt) begin
        if (mem_write) begin
          wr_cnt++;
          mem[mem_addr] = mem_wdata;
          if (exp_a.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: addr=0x%0h data=0x%0h", mem_addr, mem_wdata);
          end else begin
            chk("wr_addr", {16'h0, mem_addr}, {16'h0, exp_a.pop_front()});
            chk("wr_data", mem_wdata, exp_d.pop_front());
          end
        end else begin
          rd_cnt++;
          t = cyc + (rand_mode ? $urandom_range(1, 8) : 1);
          if (rq_t.size() > 0 && t < rq_t[$]) t = rq_t[$];
          rq_d.push_back(mem[mem_addr]);
          rq_t.push_back(t);
        end
      end
      if (rq_d.size() > max_out) max_out = rq_d.size();
      p_pend = mem_req && !mem_gnt && rst_n;
      p_addr = mem_addr; p_wd = mem_wdata; p_wr = mem_write;
    end
  end

  task automatic drive_cfg(input logic [15:0] ab, bb, cb, as, bs, cs, m, k, n);
    aBASE = ab; bBASE = bb; cBASE = cb;
    aSTRIDE = as; bSTRIDE = bs; cSTRIDE = cs;
    aROWS = m; aCOLS = k; bCOLS = n;
  endtask

  task automatic run_job(input logic [15:0] ab, bb, cb, as, bs, cs, m, k, n,
                         input int exp_rd, input int exp_wr, input logic exp_ovf,
                         input bit extra_go);
    rd_cnt = 0; wr_cnt = 0;
    drive_cfg(ab, bb, cb, as, bs, cs, m, k, n);
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    chk("busy_after_go", {31'h0, busy}, 32'h1);
    chk("ret_cleared", {31'h0, ret}, 32'h0);
    for (int t = 0; t < 4000; t++) begin
      if (ret) break;
      if (extra_go && t == 10) begin
        go = 1'b1; aROWS = 16'd7; bCOLS = 16'd9; cBASE = 16'h2000;
      end
      if (extra_go && t == 11) go = 1'b0;
      @(negedge clk);
    end
    go = 1'b0;
    chk("ret_done", {31'h0, ret}, 32'h1);
    chk("busy_done", {31'h0, busy}, 32'h0);
    chk("rd_count", rd_cnt, exp_rd);
    chk("wr_count", wr_cnt, exp_wr);
    chk("sb_empty", exp_a.size(), 0);
    chk("ovf", {31'h0, ovf}, {31'h0, exp_ovf});
  endtask

  task automatic load_2x2;
    mem[16'h100] = 1; mem[16'h101] = 2; mem[16'h102] = 3; mem[16'h103] = 4;
    mem[16'h200] = 5; mem[16'h201] = 6; mem[16'h202] = 7; mem[16'h203] = 8;
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0;
    drive_cfg(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
    chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_ret", {31'h0, ret}, 32'h0);
    chk("rst_ovf", {31'h0, ovf}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 2x2x2: C = [19 22; 43 50]
    load_2x2();
    push_exp(16'h300, 32'd19); push_exp(16'h301, 32'd22);
    push_exp(16'h302, 32'd43); push_exp(16'h303, 32'd50);
    run_job(16'h100, 16'h200, 16'h300, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2,
            12, 4, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("ret_held", {31'h0, ret}, 32'h1);

    // M=1 K=3 N=6: two tiles, C[n] = 321*(n+1); columns 6,7 untouched
    mem[16'h400] = 1; mem[16'h401] = 2; mem[16'h402] = 3;
    for (int n = 0; n < 6; n++) begin
      mem[16'h500 + n] = 32'(n + 1);
      mem[16'h508 + n] = 32'(10 * (n + 1));
      mem[16'h510 + n] = 32'(100 * (n + 1));
      push_exp(16'h600 + 16'(n), 32'(321 * (n + 1)));
    end
    mem[16'h506] = 32'hDEAD; mem[16'h507] = 32'hDEAD;
    mem[16'h606] = 32'hBEEF; mem[16'h607] = 32'hBEEF;
    run_job(16'h400, 16'h500, 16'h600, 16'd3, 16'd8, 16'd8, 16'd1, 16'd3, 16'd6,
            24, 6, 1'b0, 1'b0);
    chk("sentinel_col6", mem[16'h606], 32'hBEEF);
    chk("sentinel_col7", mem[16'h607], 32'hBEEF);

    // 0xFFFF*0xFFFF twice; upper rdata bits must be ignored
    mem[16'hA00] = 32'h1234FFFF; mem[16'hA01] = 32'h8765FFFF;
    mem[16'hB00] = 32'hFFFFFFFF; mem[16'hB01] = 32'h0000FFFF;
`ifdef MATMUL_SAT_EN
    push_exp(16'hC00, 32'hFFFFFFFF);
    run_job(16'hA00, 16'hB00, 16'hC00, 16'd2, 16'd1, 16'd1, 16'd1, 16'd2, 16'd1,
            4, 1, 1'b1, 1'b0);
`else
    push_exp(16'hC00, 32'hFFFC0002);
    run_job(16'hA00, 16'hB00, 16'hC00, 16'd2, 16'd1, 16'd1, 16'd1, 16'd2, 16'd1,
            4, 1, 1'b0, 1'b0);
`endif

    // random grant/latency, 2x3 * 3x2 = [58 64; 139 154], go while busy
    mem[16'h700] = 1; mem[16'h701] = 2; mem[16'h702] = 3;
    mem[16'h704] = 4; mem[16'h705] = 5; mem[16'h706] = 6;
    mem[16'h800] = 7;  mem[16'h801] = 8;
    mem[16'h805] = 9;  mem[16'h806] = 10;
    mem[16'h80A] = 11; mem[16'h80B] = 12;
    push_exp(16'h900, 32'd58);  push_exp(16'h901, 32'd64);
    push_exp(16'h903, 32'd139); push_exp(16'h904, 32'd154);
    rand_mode = 1'b1; max_out = 0; stab_err = 0;
    run_job(16'h700, 16'h800, 16'h900, 16'd4, 16'd5, 16'd3, 16'd2, 16'd3, 16'd2,
            18, 4, 1'b0, 1'b1);
    chk("max_outst_le2", {31'h0, (max_out <= 2)}, 32'h1);
    chk("req_stable", stab_err, 0);
    rand_mode = 1'b0;

    // reset in the middle of a B burst, then stray returns
    rd_cnt = 0;
    drive_cfg(16'h100, 16'h200, 16'hD00, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2);
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (rd_cnt >= 5) break;
      @(negedge clk);
    end
    chk("abort_point", {31'h0, (rd_cnt >= 5)}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_mem_req", {31'h0, mem_req}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_ret", {31'h0, ret}, 32'h0);
    chk("abort_ovf", {31'h0, ovf}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (rq_t.size() == 0) break;
      @(negedge clk);
    end
    stray_n = 3;
    repeat (6) @(negedge clk);

    // K = 0: immediate completion, no bus traffic
    req_cnt = 0;
    drive_cfg(16'h100, 16'h200, 16'hE00, 16'd2, 16'd2, 16'd2, 16'd2, 16'd0, 16'd2);
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    chk("zero_ret", {31'h0, ret}, 32'h1);
    chk("zero_busy", {31'h0, busy}, 32'h0);
    repeat (4) @(negedge clk);
    chk("zero_no_req", req_cnt, 0);

    // fresh job after the abort
    push_exp(16'hD00, 32'd19); push_exp(16'hD01, 32'd22);
    push_exp(16'hD02, 32'd43); push_exp(16'hD03, 32'd50);
    run_job(16'h100, 16'h200, 16'hD00, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2,
            12, 4, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
